// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment width, blank pattern, BCD digit type, decoder.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package seg7_pkg;

    localparam int SEG_W = 7;

    typedef logic [3:0]       bcd_t;
    typedef logic [SEG_W-1:0] seg_t;

    // Active-low gfedcba patterns.
    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam seg_t SEG_ZERO  = 7'b1000000;

    // Any non-decimal code is read as 0 so a corrupted digit can never escape 0-9.
    function automatic bcd_t bcd_sane(input bcd_t d);
        return (d > 4'd9) ? 4'd0 : d;
    endfunction

    function automatic seg_t seg7_of(input bcd_t bcd);
        seg_t s;
        case (bcd_sane(bcd))
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_ZERO;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// One BCD digit to active-low gfedcba segments, with a blank override.
// Latency: combinational.
// Backpressure: not applicable.
module seg7_decode
    import seg7_pkg::*;
(
    input  bcd_t bcd,
    input  logic blank,
    output seg_t seg
);

    // Blank wins over the digit pattern.
    always_comb begin
        seg = seg7_of(bcd);
        if (blank) begin
            seg = SEG_BLANK;
        end
    end

endmodule

// File: rtl/bcd_press_counter.sv
// Counts debounced button rising edges as a cascaded BCD up/down counter driving 7-seg displays.
// Latency: count_bcd/wrap update at the edge that samples the rising level; hex one edge later.
// Backpressure: none; every qualifying edge is counted, clr takes priority and discards edges.
module bcd_press_counter
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  up_lvl,
    input  logic                  dn_lvl,
    input  logic                  clr,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic [SEG_W*DIGITS-1:0] hex,
    output logic                  wrap
);

    // Previous levels reset high so a button held through reset does not count.
    logic                           r_up_prev;
    logic                           r_dn_prev;
    logic [DIGITS-1:0][3:0]         r_count;
    logic                           r_wrap;
    logic [DIGITS-1:0][SEG_W-1:0]   r_hex;

    logic                           w_up_ev;
    logic                           w_dn_ev;
    logic [DIGITS-1:0][3:0]         w_inc;
    logic                           w_inc_wrap;
    logic [DIGITS-1:0][3:0]         w_dec;
    logic                           w_dec_wrap;
    logic [DIGITS-1:0][3:0]         w_count_nxt;
    logic                           w_wrap_nxt;
    logic [DIGITS-1:0]              w_blank;
    logic [DIGITS-1:0][SEG_W-1:0]   w_seg;

    // Rising-edge detect on the debounced levels.
    always_comb begin
        w_up_ev = up_lvl & ~r_up_prev;
        w_dn_ev = dn_lvl & ~r_dn_prev;
    end

    // Increment cascade: a 9 rolls to 0 and carries upward; carry out of the top digit is a wrap.
    always_comb begin : inc_cascade
        logic w_carry;
        bcd_t w_d;
        w_carry = 1'b1;
        w_d     = 4'd0;
        w_inc   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_d = bcd_sane(r_count[i]);
            if (w_carry) begin
                if (w_d == 4'd9) begin
                    w_inc[i] = 4'd0;
                end else begin
                    w_inc[i] = w_d + 4'd1;
                    w_carry  = 1'b0;
                end
            end else begin
                w_inc[i] = w_d;
            end
        end
        w_inc_wrap = w_carry;
    end

    // Decrement cascade: a 0 rolls to 9 and borrows upward; borrow out of the top digit is a wrap.
    always_comb begin : dec_cascade
        logic w_borrow;
        bcd_t w_d;
        w_borrow = 1'b1;
        w_d      = 4'd0;
        w_dec    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_d = bcd_sane(r_count[i]);
            if (w_borrow) begin
                if (w_d == 4'd0) begin
                    w_dec[i] = 4'd9;
                end else begin
                    w_dec[i] = w_d - 4'd1;
                    w_borrow = 1'b0;
                end
            end else begin
                w_dec[i] = w_d;
            end
        end
        w_dec_wrap = w_borrow;
    end

    // Next count/wrap: clr beats everything, simultaneous up and down cancel.
    always_comb begin
        w_count_nxt = r_count;
        w_wrap_nxt  = r_wrap;
        if (clr) begin
            w_count_nxt = '0;
            w_wrap_nxt  = 1'b0;
        end else if (w_up_ev && w_dn_ev) begin
            w_count_nxt = r_count;
        end else if (w_up_ev) begin
            w_count_nxt = w_inc;
            w_wrap_nxt  = r_wrap | w_inc_wrap;
        end else if (w_dn_ev) begin
            w_count_nxt = w_dec;
            w_wrap_nxt  = r_wrap | w_dec_wrap;
        end
    end

    // Counter, sticky wrap and edge-detect history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_up_prev <= 1'b1;
            r_dn_prev <= 1'b1;
            r_count   <= '0;
            r_wrap    <= 1'b0;
        end else begin
            r_up_prev <= up_lvl;
            r_dn_prev <= dn_lvl;
            r_count   <= w_count_nxt;
            r_wrap    <= w_wrap_nxt;
        end
    end

    // Leading-zero blanking: walk down from the top digit while everything seen so far is zero.
    always_comb begin : blank_chain
        logic w_zero_hi;
        w_zero_hi = 1'b1;
        w_blank   = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zero_hi  = w_zero_hi & (bcd_sane(r_count[i]) == 4'd0);
            w_blank[i] = BLANK_LEADING && (i != 0) && w_zero_hi;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        seg7_decode u_dec (
            .bcd   (r_count[g]),
            .blank (w_blank[g]),
            .seg   (w_seg[g])
        );
    end

    // Registered display: reset shows a lone 0 (or all zeros when blanking is off).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) begin
                r_hex[i] <= (BLANK_LEADING && (i != 0)) ? SEG_BLANK : SEG_ZERO;
            end
        end else begin
            r_hex <= w_seg;
        end
    end

    assign count_bcd = r_count;
    assign hex       = r_hex;
    assign wrap      = r_wrap;

endmodule

// File: tb/tb_bcd_press_counter.sv
// Bench for bcd_press_counter: integer-valued reference model plus directed literal checks.
// Two DUTs share stimulus: one with leading-zero blanking, one without.
module tb_bcd_press_counter;

    localparam int MOD = 10000;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;

    logic        clk;
    logic        rst_n;
    logic        up_lvl;
    logic        dn_lvl;
    logic        clr;
    logic [15:0] count0, count1;
    logic [27:0] hex0, hex1;
    logic        wrap0, wrap1;

    bcd_press_counter #(.DIGITS(4), .BLANK_LEADING(1'b1)) u_dut_blank (
        .clk(clk), .rst_n(rst_n), .up_lvl(up_lvl), .dn_lvl(dn_lvl), .clr(clr),
        .count_bcd(count0), .hex(hex0), .wrap(wrap0)
    );

    bcd_press_counter #(.DIGITS(4), .BLANK_LEADING(1'b0)) u_dut_full (
        .clk(clk), .rst_n(rst_n), .up_lvl(up_lvl), .dn_lvl(dn_lvl), .clr(clr),
        .count_bcd(count1), .hex(hex1), .wrap(wrap1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (integer count) ----------------
    int m_count;
    int m_disp;
    bit m_wrap;
    bit m_up_prev;
    bit m_dn_prev;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_count   <= 0;
            m_disp    <= 0;
            m_wrap    <= 1'b0;
            m_up_prev <= 1'b1;
            m_dn_prev <= 1'b1;
        end else begin
            m_up_prev <= up_lvl;
            m_dn_prev <= dn_lvl;
            m_disp    <= m_count;
            if (clr) begin
                m_count <= 0;
                m_wrap  <= 1'b0;
            end else if (up_lvl && !m_up_prev && dn_lvl && !m_dn_prev) begin
                m_count <= m_count;
            end else if (up_lvl && !m_up_prev) begin
                m_count <= (m_count + 1) % MOD;
                if (m_count == MOD - 1) m_wrap <= 1'b1;
            end else if (dn_lvl && !m_dn_prev) begin
                m_count <= (m_count + MOD - 1) % MOD;
                if (m_count == 0) m_wrap <= 1'b1;
            end
        end
    end

    function automatic logic [6:0] seg_of_digit(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [27:0] exp_hex(input int v, input bit blank_en);
        logic [27:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            if (blank_en && i > 0 && v < p) r[7*i +: 7] = SB;
            else                            r[7*i +: 7] = seg_of_digit((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // ---------------- literal expectations, checked by the compare process ----------------
    // kind: 0 count (blank DUT), 1 wrap (blank DUT), 2 hex (blank DUT), 3 hex (full DUT)
    typedef struct {
        string       name;
        int          kind;
        logic [31:0] val;
    } lit_t;

    lit_t lits [64];
    int   n_lit_w = 0;
    int   n_lit_r = 0;

    task automatic push_lit(input string nm, input int kind, input logic [31:0] v);
        lits[n_lit_w].name = nm;
        lits[n_lit_w].kind = kind;
        lits[n_lit_w].val  = v;
        n_lit_w++;
    endtask

    // ---------------- compare process ----------------
    int n_chk  = 0;
    int n_fail = 0;

    initial begin
        logic [31:0] act;
        forever begin
            @(negedge clk);
            n_chk++;
            if (count0 !== to_bcd(m_count)) begin
                n_fail++;
                $display("FAIL model_count t=%0t got %h want %h", $time, count0, to_bcd(m_count));
            end
            n_chk++;
            if (count1 !== to_bcd(m_count)) begin
                n_fail++;
                $display("FAIL model_count_full t=%0t got %h want %h", $time, count1, to_bcd(m_count));
            end
            n_chk++;
            if (wrap0 !== m_wrap || wrap1 !== m_wrap) begin
                n_fail++;
                $display("FAIL model_wrap t=%0t got %b/%b want %b", $time, wrap0, wrap1, m_wrap);
            end
            n_chk++;
            if (hex0 !== exp_hex(m_disp, 1'b1)) begin
                n_fail++;
                $display("FAIL model_hex_blank t=%0t got %h want %h", $time, hex0, exp_hex(m_disp, 1'b1));
            end
            n_chk++;
            if (hex1 !== exp_hex(m_disp, 1'b0)) begin
                n_fail++;
                $display("FAIL model_hex_full t=%0t got %h want %h", $time, hex1, exp_hex(m_disp, 1'b0));
            end
            while (n_lit_r < n_lit_w) begin
                case (lits[n_lit_r].kind)
                    0:       act = {16'h0, count0};
                    1:       act = {31'h0, wrap0};
                    2:       act = {4'h0, hex0};
                    default: act = {4'h0, hex1};
                endcase
                n_chk++;
                if (act !== lits[n_lit_r].val) begin
                    n_fail++;
                    $display("FAIL %s t=%0t got %h want %h", lits[n_lit_r].name, $time, act, lits[n_lit_r].val);
                end
                n_lit_r++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic up_edges(input int n);
        repeat (n) begin
            up_lvl = 1'b0;
            tick();
            up_lvl = 1'b1;
            tick();
        end
    endtask

    task automatic do_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        up_lvl = 1'b1;
        dn_lvl = 1'b0;
        clr    = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        // Button held through reset: no count.
        repeat (10) tick();
        push_lit("held_count", 0, 32'h0000);
        push_lit("held_wrap", 1, 32'd0);
        push_lit("held_hex", 2, {4'h0, SB, SB, SB, S0});
        push_lit("held_hex_full", 3, {4'h0, S0, S0, S0, S0});

        // Drop and re-raise: count now, display one cycle later.
        up_lvl = 1'b0;
        tick();
        up_lvl = 1'b1;
        tick();
        push_lit("first_count", 0, 32'h0001);
        push_lit("first_hex_lag", 2, {4'h0, SB, SB, SB, S0});
        tick();
        push_lit("first_hex", 2, {4'h0, SB, SB, SB, S1});

        // Roll over the top: 9999 then +1.
        do_clear();
        up_edges(9999);
        push_lit("preload_count", 0, 32'h9999);
        push_lit("preload_wrap", 1, 32'd0);
        up_edges(1);
        push_lit("wrap_up_count", 0, 32'h0000);
        push_lit("wrap_up_flag", 1, 32'd1);
        do_clear();
        push_lit("clr_wrap", 1, 32'd0);

        // Borrow below zero.
        dn_lvl = 1'b1;
        tick();
        push_lit("wrap_dn_count", 0, 32'h9999);
        push_lit("wrap_dn_flag", 1, 32'd1);
        tick();
        push_lit("wrap_dn_hex", 2, {4'h0, S9, S9, S9, S9});
        dn_lvl = 1'b0;
        tick();

        // Carry across two digits: 0109 -> 0110.
        do_clear();
        up_edges(109);
        up_edges(1);
        push_lit("carry_count", 0, 32'h0110);
        tick();
        push_lit("carry_hex", 2, {4'h0, SB, S1, S1, S0});
        push_lit("carry_hex_full", 3, {4'h0, S0, S1, S1, S0});

        // Simultaneous up/down cancels; clr beats a coincident up edge.
        do_clear();
        up_edges(42);
        up_lvl = 1'b0;
        dn_lvl = 1'b0;
        tick();
        up_lvl = 1'b1;
        dn_lvl = 1'b1;
        tick();
        push_lit("both_edges", 0, 32'h0042);
        up_lvl = 1'b0;
        dn_lvl = 1'b0;
        tick();
        up_lvl = 1'b1;
        clr    = 1'b1;
        tick();
        clr    = 1'b0;
        push_lit("clr_vs_up", 0, 32'h0000);
        repeat (3) tick();
        push_lit("clr_vs_up_held", 0, 32'h0000);

        // Reach 0573 with wrap set, then reset asynchronously between edges.
        dn_lvl = 1'b1;
        tick();
        up_edges(574);
        push_lit("pre_rst_count", 0, 32'h0573);
        push_lit("pre_rst_wrap", 1, 32'd1);
        tick();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        push_lit("arst_count", 0, 32'h0000);
        push_lit("arst_wrap", 1, 32'd0);
        push_lit("arst_hex", 2, {4'h0, SB, SB, SB, S0});
        push_lit("arst_hex_full", 3, {4'h0, S0, S0, S0, S0});
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
